uc_multiciclo: RTL and testbench

- Parametrised next-generation control unit for the accumulator/stack CPU.
- Decodes the 6-bit opcode like the current single-cycle unit (ALU, load immediate, jump, jz, jnz, push, pop).
- Adds multi-cycle CALL/RET, HALT, a stack-occupancy tracker with overflow/underflow trapping, and a PC stall output.
- Sits between instruction memory and the datapath; drives the PC mux, register-file write, flag write and stack controls.

---
 rtl/uc_pkg.sv | 31 +++
 rtl/uc_stk_cnt.sv | 29 ++
 rtl/uc_multiciclo.sv | 226 ++++++++++++++++++++++
 tb/tb_uc_multiciclo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states, ALU defaults.
// Build option: define UC_IRQ_EN to add the interrupt entry state IRQ2.
package uc_pkg;

  // Control/stack opcodes (bit 5 set); anything with bit 5 clear is an ALU op
  localparam logic [5:0] OP_LDI  = 6'b100000;
  localparam logic [5:0] OP_JMP  = 6'b100001;
  localparam logic [5:0] OP_JZ   = 6'b100010;
  localparam logic [5:0] OP_JNZ  = 6'b100011;
  localparam logic [5:0] OP_PUSH = 6'b100100;
  localparam logic [5:0] OP_POP  = 6'b100101;
  localparam logic [5:0] OP_CALL = 6'b100110;
  localparam logic [5:0] OP_RET  = 6'b100111;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // ALU operation driven when no ALU instruction is being executed
  localparam logic [2:0] ALU_IDLE = 3'b000;

  // Control FSM states; IRQ2 only exists when interrupts are built in
  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_CALL2 = 3'd1,
    ST_RET2  = 3'd2,
    ST_HALT  = 3'd3
`ifdef UC_IRQ_EN
    ,
    ST_IRQ2  = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/uc_stk_cnt.sv
// Saturating stack occupancy counter with full/empty flags.
module uc_stk_cnt #(
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            full,
  output logic            empty
);

  assign full  = (cnt == CNTW'(DEPTH));
  assign empty = (cnt == '0);

  // Occupancy register: never wraps, ignores inc when full and dec when empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + CNTW'(1);
    end else if (dec && !inc && !empty) begin
      cnt <= cnt - CNTW'(1);
    end
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit for the accumulator/stack CPU: decode, CALL/RET sequencing,
// HALT, and stack overflow/underflow trapping.
// Build option: define UC_IRQ_EN to add irq/ie inputs, irq_ack/s_vec outputs and IRQ2.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int ALUW        = 3,
  parameter int STACK_DEPTH = 8,
  parameter int CNTW        = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            z,
`ifdef UC_IRQ_EN
  input  logic            irq,
  input  logic            ie,
  output logic            irq_ack,
  output logic            s_vec,
`endif
  output logic            s_inc,
  output logic            s_inm,
  output logic            we3,
  output logic            wez,
  output logic            s_pila,
  output logic            push,
  output logic            pop,
  output logic            s_ret,
  output logic            pc_en,
  output logic [ALUW-1:0] op_alu,
  output logic            halted,
  output logic            stk_err,
  output logic [CNTW-1:0] stk_cnt
);

  state_t state;
  state_t state_nxt;

  logic cnt_inc;
  logic cnt_dec;
  logic cnt_full;
  logic cnt_empty;
  logic err_set;

`ifdef UC_IRQ_EN
  // An interrupt is only taken on instructions that do not themselves stall the PC
  logic irq_take;
  assign irq_take = irq && ie &&
                    (opcode != OP_CALL) && (opcode != OP_RET) && (opcode != OP_HALT);
`endif

  uc_stk_cnt #(
    .DEPTH (STACK_DEPTH),
    .CNTW  (CNTW)
  ) u_stk_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .dec   (cnt_dec),
    .cnt   (stk_cnt),
    .full  (cnt_full),
    .empty (cnt_empty)
  );

  // State register; reset always returns to RUN, even mid CALL/RET
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Sticky stack error flag, set by any trapped push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_err <= 1'b0;
    end else if (err_set) begin
      stk_err <= 1'b1;
    end
  end

  // Decode and next-state logic; a trapped stack access stalls the PC and halts
  always_comb begin
    state_nxt = state;
    s_inc     = 1'b1;
    s_inm     = 1'b0;
    we3       = 1'b0;
    wez       = 1'b0;
    s_pila    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    s_ret     = 1'b0;
    pc_en     = 1'b1;
    op_alu    = ALU_IDLE;
    halted    = 1'b0;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    err_set   = 1'b0;
`ifdef UC_IRQ_EN
    irq_ack   = 1'b0;
    s_vec     = 1'b0;
`endif

    case (state)
      ST_RUN: begin
`ifdef UC_IRQ_EN
        if (irq_take) begin
          if (cnt_full) begin
            pc_en     = 1'b0;
            err_set   = 1'b1;
            state_nxt = ST_HALT;
          end else begin
            push      = 1'b1;
            s_pila    = 1'b1;
            pc_en     = 1'b0;
            irq_ack   = 1'b1;
            cnt_inc   = 1'b1;
            state_nxt = ST_IRQ2;
          end
        end else
`endif
        begin
          if (!opcode[OPW-1]) begin
            op_alu = opcode[ALUW+1:2];
            we3    = 1'b1;
            wez    = 1'b1;
          end else begin
            case (opcode)
              OP_LDI: begin
                s_inm = 1'b1;
                we3   = 1'b1;
              end
              OP_JMP: begin
                s_inc = 1'b0;
              end
              OP_JZ: begin
                s_inc = ~z;
              end
              OP_JNZ: begin
                s_inc = z;
              end
              OP_PUSH: begin
                if (cnt_full) begin
                  pc_en     = 1'b0;
                  err_set   = 1'b1;
                  state_nxt = ST_HALT;
                end else begin
                  push    = 1'b1;
                  s_pila  = 1'b1;
                  cnt_inc = 1'b1;
                end
              end
              OP_POP: begin
                if (cnt_empty) begin
                  pc_en     = 1'b0;
                  err_set   = 1'b1;
                  state_nxt = ST_HALT;
                end else begin
                  pop     = 1'b1;
                  s_pila  = 1'b1;
                  cnt_dec = 1'b1;
                end
              end
              OP_CALL: begin
                if (cnt_full) begin
                  pc_en     = 1'b0;
                  err_set   = 1'b1;
                  state_nxt = ST_HALT;
                end else begin
                  push      = 1'b1;
                  s_pila    = 1'b1;
                  pc_en     = 1'b0;
                  cnt_inc   = 1'b1;
                  state_nxt = ST_CALL2;
                end
              end
              OP_RET: begin
                if (cnt_empty) begin
                  pc_en     = 1'b0;
                  err_set   = 1'b1;
                  state_nxt = ST_HALT;
                end else begin
                  pop       = 1'b1;
                  s_pila    = 1'b1;
                  pc_en     = 1'b0;
                  cnt_dec   = 1'b1;
                  state_nxt = ST_RET2;
                end
              end
              OP_HALT: begin
                pc_en     = 1'b0;
                state_nxt = ST_HALT;
              end
              default: begin
              end
            endcase
          end
        end
      end
      ST_CALL2: begin
        s_inc     = 1'b0;
        state_nxt = ST_RUN;
      end
      ST_RET2: begin
        s_ret     = 1'b1;
        state_nxt = ST_RUN;
      end
`ifdef UC_IRQ_EN
      ST_IRQ2: begin
        s_vec     = 1'b1;
        state_nxt = ST_RUN;
      end
`endif
      ST_HALT: begin
        pc_en  = 1'b0;
        halted = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo: directed scenarios plus randomized opcodes
// compared against a phase/occupancy reference model.
module tb_uc_multiciclo;

  localparam int DEPTH = 8;

  localparam logic [5:0] T_LDI  = 6'h20;
  localparam logic [5:0] T_JMP  = 6'h21;
  localparam logic [5:0] T_JZ   = 6'h22;
  localparam logic [5:0] T_JNZ  = 6'h23;
  localparam logic [5:0] T_PUSH = 6'h24;
  localparam logic [5:0] T_POP  = 6'h25;
  localparam logic [5:0] T_CALL = 6'h26;
  localparam logic [5:0] T_RET  = 6'h27;
  localparam logic [5:0] T_HALT = 6'h3F;

  localparam int PH_RUN   = 0;
  localparam int PH_AFTER_CALL = 1;
  localparam int PH_AFTER_RET  = 2;
  localparam int PH_HALT  = 3;
  localparam int PH_AFTER_IRQ  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       z = 1'b0;
  logic       s_inc, s_inm, we3, wez, s_pila, push, pop, s_ret, pc_en, halted, stk_err;
  logic [2:0] op_alu;
  logic [3:0] stk_cnt;
`ifdef UC_IRQ_EN
  logic irq = 1'b0;
  logic ie  = 1'b0;
  logic irq_ack, s_vec;
`endif

  int checks = 0;
  int errors = 0;

  int m_cnt = 0;
  bit m_err = 1'b0;
  int m_phase = PH_RUN;
  int n_cnt;
  bit n_err;
  int n_phase;

  uc_multiciclo dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .z       (z),
`ifdef UC_IRQ_EN
    .irq     (irq),
    .ie      (ie),
    .irq_ack (irq_ack),
    .s_vec   (s_vec),
`endif
    .s_inc   (s_inc),
    .s_inm   (s_inm),
    .we3     (we3),
    .wez     (wez),
    .s_pila  (s_pila),
    .push    (push),
    .pop     (pop),
    .s_ret   (s_ret),
    .pc_en   (pc_en),
    .op_alu  (op_alu),
    .halted  (halted),
    .stk_err (stk_err),
    .stk_cnt (stk_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: expected outputs from occupancy, phase and inputs; also computes next model state
  task automatic checkCycle();
    logic e_s_inc, e_s_inm, e_we3, e_wez, e_s_pila, e_push, e_pop, e_s_ret, e_pc_en, e_halted;
    logic e_irq_ack, e_s_vec;
    logic [2:0] e_alu;
    bit take_irq, wants_push, wants_pop;
    e_s_inc = 1; e_s_inm = 0; e_we3 = 0; e_wez = 0; e_s_pila = 0; e_push = 0;
    e_pop = 0; e_s_ret = 0; e_pc_en = 1; e_halted = 0; e_alu = 3'd0;
    e_irq_ack = 0; e_s_vec = 0;
    n_cnt = m_cnt; n_err = m_err; n_phase = PH_RUN;
    take_irq = 0;
`ifdef UC_IRQ_EN
    take_irq = irq && ie && opcode != T_CALL && opcode != T_RET && opcode != T_HALT;
`endif
    wants_push = take_irq || opcode == T_PUSH || opcode == T_CALL;
    wants_pop  = !take_irq && (opcode == T_POP || opcode == T_RET);
    if (m_phase == PH_HALT) begin
      e_pc_en = 0; e_halted = 1; n_phase = PH_HALT;
    end else if (m_phase == PH_AFTER_CALL) begin
      e_s_inc = 0;
    end else if (m_phase == PH_AFTER_RET) begin
      e_s_ret = 1;
    end else if (m_phase == PH_AFTER_IRQ) begin
      e_s_vec = 1;
    end else if ((wants_push && m_cnt == DEPTH) || (wants_pop && m_cnt == 0)) begin
      e_pc_en = 0; n_err = 1; n_phase = PH_HALT;
    end else if (take_irq) begin
      e_push = 1; e_s_pila = 1; e_pc_en = 0; e_irq_ack = 1;
      n_cnt = m_cnt + 1; n_phase = PH_AFTER_IRQ;
    end else if (opcode < 6'd32) begin
      e_alu = 3'((int'(opcode) / 4) % 8); e_we3 = 1; e_wez = 1;
    end else if (opcode == T_LDI) begin
      e_s_inm = 1; e_we3 = 1;
    end else if (opcode == T_JMP) begin
      e_s_inc = 0;
    end else if (opcode == T_JZ) begin
      e_s_inc = !z;
    end else if (opcode == T_JNZ) begin
      e_s_inc = z;
    end else if (opcode == T_PUSH) begin
      e_push = 1; e_s_pila = 1; n_cnt = m_cnt + 1;
    end else if (opcode == T_POP) begin
      e_pop = 1; e_s_pila = 1; n_cnt = m_cnt - 1;
    end else if (opcode == T_CALL) begin
      e_push = 1; e_s_pila = 1; e_pc_en = 0; n_cnt = m_cnt + 1; n_phase = PH_AFTER_CALL;
    end else if (opcode == T_RET) begin
      e_pop = 1; e_s_pila = 1; e_pc_en = 0; n_cnt = m_cnt - 1; n_phase = PH_AFTER_RET;
    end else if (opcode == T_HALT) begin
      e_pc_en = 0; n_phase = PH_HALT;
    end
    checkOutput($sformatf("ctrl op=%b z=%b", opcode, z),
                32'({s_inc, s_inm, we3, wez, s_pila, push, pop, s_ret, pc_en, halted, op_alu}),
                32'({e_s_inc, e_s_inm, e_we3, e_wez, e_s_pila, e_push, e_pop, e_s_ret,
                     e_pc_en, e_halted, e_alu}));
    checkOutput("stk_cnt", 32'(stk_cnt), 32'(m_cnt));
    checkOutput("stk_err", 32'(stk_err), 32'(m_err));
`ifdef UC_IRQ_EN
    checkOutput("irq_ack/s_vec", 32'({irq_ack, s_vec}), 32'({e_irq_ack, e_s_vec}));
`endif
  endtask

  // Drive one instruction cycle; starts and ends at a falling edge
  task automatic applyStimulus(input logic [5:0] op, input logic zv);
    opcode = op;
    z = zv;
    #1 checkCycle();
    @(posedge clk);
    m_cnt = n_cnt; m_err = n_err; m_phase = n_phase;
    @(negedge clk);
  endtask

  // Assert reset across one rising edge; outputs must be the RUN decode with an empty stack
  task automatic resetPulse();
    reset = 1'b1;
    #1;
    m_cnt = 0; m_err = 0; m_phase = PH_RUN;
    checkCycle();
    @(posedge clk);
    #1 checkCycle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [5:0] randomOpcode();
    int r;
    logic [5:0] menu [8];
    menu = '{T_LDI, T_JMP, T_JZ, T_JNZ, T_PUSH, T_POP, T_CALL, T_RET};
    r = int'($urandom_range(0, 19));
    if (r < 6) return 6'($urandom_range(0, 31));
    if (r < 14) return menu[r - 6];
    if (r < 18) return 6'($urandom_range(40, 62));
    if (r == 18) return T_PUSH;
    return ($urandom_range(0, 3) == 0) ? T_HALT : T_CALL;
  endfunction

  initial begin
    int halt_cycles;
    @(negedge clk);
    resetPulse();

    // Basic decode
    applyStimulus(6'b000110, 1'($urandom_range(0, 1)));
    applyStimulus(6'b011111, 1'b0);
    applyStimulus(T_JZ, 1'b1);
    applyStimulus(T_JZ, 1'b0);
    applyStimulus(T_JNZ, 1'b1);
    applyStimulus(T_JNZ, 1'b0);
    applyStimulus(T_JMP, 1'b0);
    applyStimulus(T_LDI, 1'b1);
    applyStimulus(6'b101010, 1'b0);

    // CALL then RET, each held two cycles
    applyStimulus(T_CALL, 1'b0);
    applyStimulus(T_CALL, 1'b0);
    applyStimulus(T_RET, 1'b0);
    applyStimulus(T_RET, 1'b0);
    applyStimulus(T_LDI, 1'b0);

    // Overflow: 8 pushes fill the stack, the 9th traps and halts
    for (int i = 0; i < 9; i++) applyStimulus(T_PUSH, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(randomOpcode(), 1'($urandom_range(0, 1)));
    resetPulse();

    // Underflow on an empty stack
    applyStimulus(T_POP, 1'b0);
    applyStimulus(T_LDI, 1'b0);
    resetPulse();
    applyStimulus(T_RET, 1'b1);
    applyStimulus(T_RET, 1'b1);
    resetPulse();

    // Reset in the middle of CALL2, then normal decode resumes
    applyStimulus(T_PUSH, 1'b0);
    applyStimulus(T_CALL, 1'b0);
    resetPulse();
    applyStimulus(T_LDI, 1'b0);

    // HALT holds for 20 cycles whatever arrives on opcode/z
    applyStimulus(T_HALT, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(6'($urandom), 1'($urandom_range(0, 1)));
    resetPulse();
    applyStimulus(6'b000100, 1'b0);

`ifdef UC_IRQ_EN
    // Interrupt on an ALU op becomes a call to the vector; with ie low it is ignored
    irq = 1'b1; ie = 1'b1;
    applyStimulus(6'b000000, 1'b0);
    applyStimulus(6'b000000, 1'b0);
    ie = 1'b0;
    applyStimulus(6'b000000, 1'b0);
    irq = 1'b1; ie = 1'b1;
    applyStimulus(T_CALL, 1'b0);
    applyStimulus(T_CALL, 1'b0);
    irq = 1'b0; ie = 1'b0;
    resetPulse();
`endif

    // Randomized instruction stream with occasional resets
    halt_cycles = 0;
    for (int i = 0; i < 600; i++) begin
`ifdef UC_IRQ_EN
      irq = ($urandom_range(0, 7) == 0);
      ie  = 1'($urandom_range(0, 1));
`endif
      if (m_phase == PH_HALT) halt_cycles++;
      if (halt_cycles > 3 || $urandom_range(0, 59) == 0) begin
        halt_cycles = 0;
        resetPulse();
      end else begin
        applyStimulus(randomOpcode(), 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
